// File: rtl/fetch_unit.sv
// fetch_unit: program counter, memory address register and instruction
// register for the 8-bit CPU. Sits between the shared bus and control_unit.
//
// Optional feature macro: COND_JUMP_EN
//   defined   -> jc & flag loads the PC from the bus (after j, before ce)
//   undefined -> jc and flag are accepted but ignored
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   bus_in          shared bus value this cycle
//   co / io         drive PC / IR operand onto the bus
//   ce, j, jc, flag PC count, jump, conditional jump, jump condition
//   mi / ii         load MAR / IR from the bus
//   hlt             halt request (sticky once taken)
//   bus_out, bus_oe value driven to the bus and its valid flag
//   mem_addr        MAR
//   inst            IR opcode field
//   pc              PC (debug/display)
//   halted, bus_err sticky status bits, cleared only by reset
module fetch_unit #(
    parameter int DATA_W = 8,
    parameter int OPC_W  = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              co,
    input  logic              ce,
    input  logic              j,
    input  logic              jc,
    input  logic              flag,
    input  logic              mi,
    input  logic              ii,
    input  logic              io,
    input  logic              hlt,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [OPC_W-1:0]  inst,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              bus_err
);

    // The IR splits cleanly into opcode and operand only when the widths add up.
    generate
        if (ADDR_W != DATA_W - OPC_W) begin : g_width_check
            $error("fetch_unit: ADDR_W must equal DATA_W-OPC_W");
        end
    endgenerate

    logic [ADDR_W-1:0] pc_q,  pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] ir_q,  ir_d;
    logic              halted_q, halted_d;
    logic              bus_err_q, bus_err_d;

`ifndef COND_JUMP_EN
    // Ports kept for a uniform top level; nothing consumes them in this build.
    logic unused_cond;
    assign unused_cond = jc ^ flag;
`endif

    always_comb begin
        pc_d = pc_q;
        // A halted core freezes its PC; only reset restarts it.
        if (!halted_q) begin
            if (j) begin
                pc_d = bus_in[ADDR_W-1:0];
`ifdef COND_JUMP_EN
            end else if (jc && flag) begin
                pc_d = bus_in[ADDR_W-1:0];
`endif
            end else if (ce) begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end

        // MAR and IR keep loading while halted so the bus stays observable.
        mar_d = mi ? bus_in[ADDR_W-1:0] : mar_q;
        ir_d  = ii ? bus_in : ir_q;

        halted_d  = halted_q | hlt;
        bus_err_d = bus_err_q | (co & io);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= '0;
            mar_q     <= '0;
            ir_q      <= '0;
            halted_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            mar_q     <= mar_d;
            ir_q      <= ir_d;
            halted_q  <= halted_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Bus drive is combinational; on a co/io collision the PC wins.
    always_comb begin
        bus_out = '0;
        if (co) begin
            bus_out = DATA_W'(pc_q);
        end else if (io) begin
            bus_out = DATA_W'(ir_q[ADDR_W-1:0]);
        end
    end

    assign bus_oe   = co | io;
    assign mem_addr = mar_q;
    assign inst     = ir_q[DATA_W-1 -: OPC_W];
    assign pc       = pc_q;
    assign halted   = halted_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

`ifdef COND_JUMP_EN
    localparam bit CJ = 1'b1;
`else
    localparam bit CJ = 1'b0;
`endif

    logic       clk, rst;
    logic [7:0] bus_in;
    logic       co, ce, j, jc, flag, mi, ii, io, hlt;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [3:0] mem_addr, inst, pc;
    logic       halted, bus_err;

    fetch_unit #(.DATA_W(8), .OPC_W(4), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in),
        .co(co), .ce(ce), .j(j), .jc(jc), .flag(flag),
        .mi(mi), .ii(ii), .io(io), .hlt(hlt),
        .bus_out(bus_out), .bus_oe(bus_oe), .mem_addr(mem_addr),
        .inst(inst), .pc(pc), .halted(halted), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        co = 0; ce = 0; j = 0; jc = 0; flag = 0;
        mi = 0; ii = 0; io = 0; hlt = 0; bus_in = 8'h00;
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted between edges; state must clear without waiting for a clock.
    task automatic do_reset();
        idle();
        rst = 0;
        #1;
        chk("rst_pc", pc, 0);
        chk("rst_mar", mem_addr, 0);
        chk("rst_inst", inst, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err", bus_err, 0);
        #1;
        rst = 1;
    endtask

    typedef struct {
        logic       co, ce, j, jc, flag, mi, ii, io, hlt;
        logic [7:0] bus_in;
        logic [7:0] e_out;
        logic       e_oe;
        logic [3:0] e_pc, e_mar, e_inst;
        logic       e_halt, e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic c_o, c_e, c_j, c_jc, c_f, c_mi, c_ii, c_io, c_h,
                       input logic [7:0] b, e_o, input logic e_oe,
                       input logic [3:0] e_p, e_m, e_i, input logic e_h, e_e);
        vec_t v;
        v.co = c_o; v.ce = c_e; v.j = c_j; v.jc = c_jc; v.flag = c_f;
        v.mi = c_mi; v.ii = c_ii; v.io = c_io; v.hlt = c_h; v.bus_in = b;
        v.e_out = e_o; v.e_oe = e_oe; v.e_pc = e_p; v.e_mar = e_m; v.e_inst = e_i;
        v.e_halt = e_h; v.e_err = e_e;
        vecs.push_back(v);
    endtask

    // Reference model state
    int m_pc, m_mar, m_ir;
    bit m_halt, m_err;

    initial begin
        rst = 1;
        idle();
        #2;

        // ---- Directed table, applied from a fresh reset ----
        //   co ce j jc f mi ii io h  bus    out  oe  pc mar inst h e
        add(0,1,0,0,0,0,0,0,0, 8'h00, 8'h00,0, 1,0,0,0,0);
        add(0,0,1,0,0,0,0,0,0, 8'h05, 8'h00,0, 5,0,0,0,0);
        add(1,0,0,0,0,1,0,0,0, 8'h05, 8'h05,1, 5,5,0,0,0);
        add(0,0,0,0,0,0,1,0,0, 8'h2A, 8'h00,0, 5,5,2,0,0);
        add(0,0,0,0,0,0,0,1,0, 8'h0A, 8'h0A,1, 5,5,2,0,0);
        add(0,0,1,0,0,0,0,0,0, 8'h07, 8'h00,0, 7,5,2,0,0);
        add(0,1,1,0,0,0,0,0,0, 8'h03, 8'h00,0, 3,5,2,0,0);
        add(1,1,0,0,0,0,0,0,0, 8'h03, 8'h03,1, 4,5,2,0,0);
        add(0,0,1,0,0,0,0,0,0, 8'h02, 8'h00,0, 2,5,2,0,0);
        add(0,0,0,0,0,0,1,0,0, 8'h59, 8'h00,0, 2,5,5,0,0);
        add(1,0,0,0,0,0,0,1,0, 8'h02, 8'h02,1, 2,5,5,0,1);
        add(0,0,0,0,0,0,0,0,0, 8'h00, 8'h00,0, 2,5,5,0,1);
        add(0,0,1,0,0,0,0,0,0, 8'h0F, 8'h00,0, 15,5,5,0,1);
        add(0,1,0,0,0,0,0,0,0, 8'h00, 8'h00,0, 0,5,5,0,1);
        add(0,0,0,0,0,1,0,0,0, 8'hFB, 8'h00,0, 0,11,5,0,1);
        add(0,0,1,0,0,0,0,0,0, 8'hF6, 8'h00,0, 6,11,5,0,1);
        add(0,0,0,0,0,0,0,0,1, 8'h00, 8'h00,0, 6,11,5,1,1);
        add(0,1,1,0,0,0,0,0,0, 8'h09, 8'h00,0, 6,11,5,1,1);
        add(0,0,0,0,0,0,1,0,0, 8'h3C, 8'h00,0, 6,11,3,1,1);
        add(0,1,0,0,0,1,0,0,0, 8'h01, 8'h00,0, 6,1,3,1,1);
        add(1,1,0,1,1,0,0,0,0, 8'h06, 8'h06,1, 6,1,3,1,1);

        @(posedge clk); #1;
        do_reset();
        foreach (vecs[k]) begin
            co = vecs[k].co; ce = vecs[k].ce; j = vecs[k].j; jc = vecs[k].jc;
            flag = vecs[k].flag; mi = vecs[k].mi; ii = vecs[k].ii; io = vecs[k].io;
            hlt = vecs[k].hlt; bus_in = vecs[k].bus_in;
            #1;
            chk($sformatf("tbl%0d_bus_out", k), bus_out, vecs[k].e_out);
            chk($sformatf("tbl%0d_bus_oe", k), bus_oe, vecs[k].e_oe);
            step();
            idle();
            chk($sformatf("tbl%0d_pc", k), pc, vecs[k].e_pc);
            chk($sformatf("tbl%0d_mar", k), mem_addr, vecs[k].e_mar);
            chk($sformatf("tbl%0d_inst", k), inst, vecs[k].e_inst);
            chk($sformatf("tbl%0d_halted", k), halted, vecs[k].e_halt);
            chk($sformatf("tbl%0d_err", k), bus_err, vecs[k].e_err);
        end

        // ---- PC count and wrap: 20 edges from reset ----
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            ce = 1;
            step();
            chk($sformatf("count_e%0d", e), pc, e % 16);
        end

        // ---- Halt at PC=4, jumps/counts ignored, reset resumes ----
        do_reset();
        j = 1; bus_in = 8'h04; step(); idle();
        hlt = 1; step(); idle();
        for (int c = 0; c < 5; c++) begin
            ce = 1; j = 1; bus_in = 8'h0E;
            step();
        end
        idle();
        chk("halt_pc", pc, 4);
        chk("halt_flag", halted, 1);
        ii = 1; bus_in = 8'hC3; step(); idle();
        chk("halt_ir_load", inst, 4'hC);
        do_reset();
        ce = 1; step(); idle();
        chk("post_halt_pc", pc, 1);
        chk("post_halt_flag", halted, 0);

        // ---- Conditional jump ----
        do_reset();
        j = 1; bus_in = 8'h06; step(); idle();
        jc = 1; flag = 0; ce = 1; bus_in = 8'h0C; step(); idle();
        chk("cj_nottaken", pc, 7);
        jc = 1; flag = 1; ce = 1; bus_in = 8'h0C; step(); idle();
        chk("cj_taken", pc, CJ ? 12 : 8);

        // ---- Randomized against reference model ----
        do_reset();
        m_pc = 0; m_mar = 0; m_ir = 0; m_halt = 0; m_err = 0;
        for (int n = 0; n < 600; n++) begin
            int e_out;
            bit e_oe;
            if ($urandom_range(0, 39) == 0) begin
                do_reset();
                m_pc = 0; m_mar = 0; m_ir = 0; m_halt = 0; m_err = 0;
            end
            co = $urandom_range(0, 3) == 0; io = $urandom_range(0, 3) == 0;
            ce = $urandom_range(0, 1);  j = $urandom_range(0, 5) == 0;
            jc = $urandom_range(0, 3) == 0; flag = $urandom_range(0, 1);
            mi = $urandom_range(0, 3) == 0; ii = $urandom_range(0, 3) == 0;
            hlt = $urandom_range(0, 59) == 0;
            e_oe  = co || io;
            e_out = co ? m_pc : (io ? (m_ir % 16) : 0);
            bus_in = e_oe ? 8'(e_out) : 8'($urandom_range(0, 255));
            #1;
            chk("rnd_bus_out", bus_out, e_out);
            chk("rnd_bus_oe", bus_oe, e_oe);
            // model update from pre-edge values
            if (!m_halt) begin
                if (j || (CJ && jc && flag)) m_pc = bus_in % 16;
                else if (ce)                 m_pc = (m_pc + 1) % 16;
            end
            if (mi) m_mar = bus_in % 16;
            if (ii) m_ir = bus_in;
            if (hlt) m_halt = 1;
            if (co && io) m_err = 1;
            step();
            chk("rnd_pc", pc, m_pc);
            chk("rnd_mar", mem_addr, m_mar);
            chk("rnd_inst", inst, m_ir / 16);
            chk("rnd_halted", halted, m_halt);
            chk("rnd_err", bus_err, m_err);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
